uart_word_assembler: RTL and testbench

- Sits directly downstream of uart_rx. Consumes received bytes over a valid/ready handshake and packs BYTES_PER_WORD bytes into one word.
- Emits each word with an auto-incrementing address, so the RSA pipeline CPU's memory loader can be filled over UART.
- An inter-byte timeout discards a partial word so the stream resynchronises after a dropped byte.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_asm_timer.sv | 28 ++
 rtl/uart_word_assembler.sv | 124 ++++++++++++
 tb/tb_uart_word_assembler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART defaults and word assembler state type
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_BAUD_RATE  = 115200;
  localparam int UART_CLK_FREQ   = 100_000_000;
  localparam int BIT_CYCLES      = UART_CLK_FREQ / UART_BAUD_RATE;

  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/uart_asm_timer.sv
// rtl/uart_asm_timer.sv - idle counter with enable, clear and single-cycle expire
module uart_asm_timer #(
  parameter int LIMIT = 34720
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] count;

  assign expire = en && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr || expire) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - packs uart_rx bytes into addressed words with inter-byte timeout
// Optional macro UART_ASM_BIG_ENDIAN_EN places the first byte in the most significant lane.
module uart_word_assembler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = UART_DATA_WIDTH,
  parameter int WORD_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 40 * BIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  clear,
  output logic [WORD_WIDTH-1:0] word_data,
  output logic [ADDR_WIDTH-1:0] word_addr,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  timeout_pulse
);

  localparam int BPW   = WORD_WIDTH / DATA_WIDTH;
  localparam int CNT_W = $clog2(BPW);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BPW - 1);

  asm_state_t            state_q, state_d;
  logic [CNT_W-1:0]      byte_cnt;
  logic [CNT_W-1:0]      lane;
  logic [WORD_WIDTH-1:0] shift_q;
  logic [WORD_WIDTH-1:0] merged;
  logic                  xfer;
  logic                  last_byte;
  logic                  timer_en;
  logic                  expire;

  // rstn gates in_ready so uart_rx sees no acceptance while held in reset
  assign in_ready   = rstn && (state_q == COLLECT) && !clear;
  assign xfer       = in_valid && in_ready;
  assign last_byte  = (byte_cnt == LAST_CNT);
  assign word_valid = (state_q == HOLD);
  assign timer_en   = (state_q == COLLECT) && (byte_cnt != '0) && !xfer && !clear;

`ifdef UART_ASM_BIG_ENDIAN_EN
  assign lane = LAST_CNT - byte_cnt;
`else
  assign lane = byte_cnt;
`endif

  always_comb begin
    merged = shift_q;
    for (int i = 0; i < BPW; i++) begin
      if (lane == CNT_W'(i)) begin
        merged[i*DATA_WIDTH +: DATA_WIDTH] = in_data;
      end
    end
  end

  uart_asm_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rstn   (rstn),
    .en     (timer_en),
    .clr    (xfer || clear),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= COLLECT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = COLLECT;
    end else begin
      unique case (state_q)
        COLLECT: if (xfer && last_byte) state_d = HOLD;
        HOLD:    if (word_ready)        state_d = COLLECT;
        default: state_d = COLLECT;
      endcase
    end
  end

  // clear outranks a transfer, which outranks a coincident timeout
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt      <= '0;
      shift_q       <= '0;
      word_data     <= '0;
      word_addr     <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      if (clear) begin
        byte_cnt  <= '0;
        shift_q   <= '0;
        word_addr <= '0;
      end else if (xfer) begin
        if (last_byte) begin
          byte_cnt  <= '0;
          shift_q   <= '0;
          word_data <= merged;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
          shift_q  <= merged;
        end
      end else if (expire) begin
        byte_cnt      <= '0;
        shift_q       <= '0;
        timeout_pulse <= 1'b1;
      end else if ((state_q == HOLD) && word_ready) begin
        word_addr <= word_addr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb/tb_uart_word_assembler.sv - directed vector bench for uart_word_assembler
module tb_uart_word_assembler;

  localparam int DW = 8;
  localparam int WW = 32;
  localparam int AW = 4;
  localparam int TO = 40;
`ifdef UART_ASM_BIG_ENDIAN_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          clear;
  logic [WW-1:0] word_data;
  logic [AW-1:0] word_addr;
  logic          word_valid;
  logic          word_ready;
  logic          timeout_pulse;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_word_assembler #(
    .DATA_WIDTH     (DW),
    .WORD_WIDTH     (WW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .clear         (clear),
    .word_data     (word_data),
    .word_addr     (word_addr),
    .word_valid    (word_valid),
    .word_ready    (word_ready),
    .timeout_pulse (timeout_pulse)
  );

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] le, be;
    logic [3:0]  addr;
    int          hold;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b0, b1, b2, b3);
    return BE ? {b0, b1, b2, b3} : {b3, b2, b1, b0};
  endfunction

  // Starts and returns just after a rising edge; the byte is taken on the edge before return.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      #1;
      if (in_ready) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    chk("byte_accept", 64'(ok), 64'(1));
  endtask

  task automatic send_word(input logic [7:0] b0, b1, b2, b3, input int gap);
    send_byte(b0);
    repeat (gap) tick();
    send_byte(b1);
    repeat (gap) tick();
    send_byte(b2);
    repeat (gap) tick();
    send_byte(b3);
  endtask

  task automatic expect_word(input logic [31:0] d, input logic [3:0] a, input int hold);
    logic [3:0] na;
    na = a + 4'd1;
    chk("word_valid_rise", 64'(word_valid), 64'(1));
    chk("word_data", 64'(word_data), 64'(d));
    chk("word_addr", 64'(word_addr), 64'(a));
    word_ready = 1'b0;
    in_valid   = 1'b1;
    in_data    = 8'h5a;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 64'(word_valid), 64'(1));
      chk("hold_data", 64'(word_data), 64'(d));
      chk("hold_addr", 64'(word_addr), 64'(a));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
    end
    in_valid   = 1'b0;
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    chk("word_valid_fall", 64'(word_valid), 64'(0));
    chk("addr_next", 64'(word_addr), 64'(na));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int pulses;
    logic [3:0] exp_addr;
    logic [7:0] rb [4];

    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 32'h11223344, 4'd0, 0};
    vecs[1] = '{8'hde, 8'had, 8'hbe, 8'hef, 32'hefbeadde, 32'hdeadbeef, 4'd1, 50};
    vecs[2] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h00000000, 32'h00000000, 4'd2, 3};
    vecs[3] = '{8'hff, 8'h01, 8'h80, 8'h7f, 32'h7f8001ff, 32'hff01807f, 4'd3, 0};

    rstn       = 1'b0;
    in_data    = '0;
    in_valid   = 1'b0;
    clear      = 1'b0;
    word_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_word_valid", 64'(word_valid), 64'(0));
    chk("rst_word_data", 64'(word_data), 64'(0));
    chk("rst_word_addr", 64'(word_addr), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_timeout", 64'(timeout_pulse), 64'(0));
    rstn = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'(1));
    tick();

    for (int v = 0; v < 4; v++) begin
      send_word(vecs[v].b0, vecs[v].b1, vecs[v].b2, vecs[v].b3, v);
      expect_word(BE ? vecs[v].be : vecs[v].le, vecs[v].addr, vecs[v].hold);
    end

    // partial word discarded by timeout, address unchanged
    send_byte(8'haa);
    send_byte(8'hbb);
    first  = -1;
    pulses = 0;
    for (int k = 0; k <= TO + 5; k++) begin
      if (timeout_pulse) begin
        pulses++;
        if (first < 0) first = k;
      end
      tick();
    end
    chk("timeout_cycle", 64'(first), 64'(TO));
    chk("timeout_once", 64'(pulses), 64'(1));
    chk("timeout_addr", 64'(word_addr), 64'(4));
    chk("timeout_no_word", 64'(word_valid), 64'(0));
    send_word(8'h01, 8'h02, 8'h03, 8'h04, 0);
    expect_word(BE ? 32'h01020304 : 32'h04030201, 4'd4, 2);

    // byte lands on the expiring cycle: transfer wins
    send_byte(8'h10);
    repeat (TO - 1) tick();
    send_byte(8'h20);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (timeout_pulse) pulses++;
      tick();
    end
    chk("coincide_no_timeout", 64'(pulses), 64'(0));
    send_byte(8'h30);
    send_byte(8'h40);
    expect_word(BE ? 32'h10203040 : 32'h40302010, 4'd5, 0);

    // clear while a word is pending
    send_word(8'h55, 8'h66, 8'h77, 8'h88, 0);
    chk("pre_clear_valid", 64'(word_valid), 64'(1));
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_valid", 64'(word_valid), 64'(0));
    chk("clear_addr", 64'(word_addr), 64'(0));
    send_word(8'ha1, 8'hb2, 8'hc3, 8'hd4, 1);
    expect_word(BE ? 32'ha1b2c3d4 : 32'hd4c3b2a1, 4'd0, 0);

    // reset mid-word
    send_byte(8'hee);
    send_byte(8'hdd);
    rstn = 1'b0;
    #1;
    chk("midrst_valid", 64'(word_valid), 64'(0));
    chk("midrst_addr", 64'(word_addr), 64'(0));
    chk("midrst_data", 64'(word_data), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    tick();
    rstn = 1'b1;
    tick();
    send_word(8'h09, 8'h08, 8'h07, 8'h06, 0);
    expect_word(BE ? 32'h09080706 : 32'h06070809, 4'd0, 1);

    // stream past the address wrap with random gaps and consumer stalls
    exp_addr = 4'd1;
    for (int w = 0; w < 17; w++) begin
      for (int j = 0; j < 4; j++) rb[j] = 8'($urandom_range(0, 255));
      send_word(rb[0], rb[1], rb[2], rb[3], int'($urandom_range(0, 3)));
      expect_word(pack(rb[0], rb[1], rb[2], rb[3]), exp_addr, int'($urandom_range(0, 4)));
      exp_addr = exp_addr + 4'd1;
    end
    chk("wrap_final_addr", 64'(word_addr), 64'(2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
